// File: rtl/wave_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wave_seq_pkg                                                    |
// | Purpose  : Shared types and constants for the wave sequencer slice:       |
// |            controller state encoding, program-entry layout and the        |
// |            fixed length of the generator-reset (LOAD) phase.               |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package wave_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  // Cycles the generator is held in reset before a step starts running.
  localparam int LOAD_CYCLES = 2;
  localparam int LOAD_CNT_W  = $clog2(LOAD_CYCLES);

  // Program entry field widths; the sequencer's SHIFT_W / REP_W must match.
  localparam int PROG_SHIFT_W = 4;
  localparam int PROG_REP_W   = 4;

  typedef struct packed {
    logic [PROG_SHIFT_W-1:0] shift;
    logic [PROG_REP_W-1:0]   rep;
  } prog_entry_t;

endpackage
`default_nettype wire

// File: rtl/wave_period_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wave_period_detect                                              |
// | Purpose  : Watches a triangle waveform and flags the cycle in which it     |
// |            turns upward after having fallen (one completed period).        |
// | Ports    : clk, reset_n   - clock, async active-low reset                  |
// |            i_clr          - sync clear of previous sample and fall flag    |
// |            i_sample       - generator output                               |
// |            o_boundary     - combinational one-cycle period-boundary pulse  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wave_period_detect
  import wave_seq_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic [OUT_W-1:0] i_sample,
  output logic             o_boundary
);

  logic [OUT_W-1:0] r_prev;
  logic             r_falling;
  logic             w_rise;
  logic             w_fall;

  assign w_rise     = (i_sample > r_prev);
  assign w_fall     = (i_sample < r_prev);
  // Only a rise that follows a fall counts; equal samples leave the flag alone.
  assign o_boundary = r_falling && w_rise && !i_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_falling <= 1'b0;
    end else if (i_clr) begin
      r_prev    <= '0;
      r_falling <= 1'b0;
    end else begin
      r_prev <= i_sample;
      if (o_boundary) begin
        r_falling <= 1'b0;
      end else if (w_fall) begin
        r_falling <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wave_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wave_sequencer                                                  |
// | Purpose  : Runs a small (rate, repeat) program on one triangle generator:  |
// |            holds it in reset between steps, sets its rate, counts wave     |
// |            periods and walks the program, optionally looping.              |
// | Ports    : clk, reset_n          - clock, async active-low reset           |
// |            start/stop/loop_en    - run control                             |
// |            wr_en/wr_addr/wr_shift/wr_rep, wr_err - program write port     |
// |            tri_out               - generator output (input here)           |
// |            tri_reset, tri_shift  - generator controls                      |
// |            step, busy, done, fault - status                                |
// | Config   : WAVE_SEQ_TIMEOUT_EN - builds the RUN watchdog that drives fault |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int STEPS     = 8,
  parameter int SHIFT_W   = PROG_SHIFT_W,
  parameter int REP_W     = PROG_REP_W,
  parameter int OUT_W     = 16,
  parameter int TIMEOUT_W = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [SHIFT_W-1:0]       wr_shift,
  input  logic [REP_W-1:0]         wr_rep,
  output logic                     wr_err,
  input  logic [OUT_W-1:0]         tri_out,
  output logic                     tri_reset,
  output logic [SHIFT_W-1:0]       tri_shift,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     busy,
  output logic                     done,
  output logic                     fault
);

  localparam int STEP_W = $clog2(STEPS);

  prog_entry_t             r_prog [STEPS];
  seq_state_t              r_state, w_state_nxt;
  logic [STEP_W-1:0]       r_step, w_step_nxt, w_step_inc;
  logic [LOAD_CNT_W-1:0]   r_load_cnt, w_load_cnt_nxt;
  logic [REP_W-1:0]        r_rep_cnt, w_rep_cnt_nxt;
  logic                    w_done_nxt;
  logic                    w_boundary;
  logic                    w_det_clr;
  logic                    w_timeout;
  logic                    w_start_ok;
  logic                    w_prog_end;
  logic                    r_tri_reset, r_busy, r_done, r_wr_err;
  logic [SHIFT_W-1:0]      r_tri_shift;

  assign w_det_clr  = (r_state != RUN);
  assign w_start_ok = (r_state == IDLE) && start && !stop;
  assign w_step_inc = r_step + STEP_W'(1);
  // Last slot, or the following slot is the end-of-program marker.
  assign w_prog_end = (r_step == STEP_W'(STEPS - 1)) || (r_prog[w_step_inc].rep == '0);

  wave_period_detect #(
    .OUT_W (OUT_W)
  ) u_detect (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (w_det_clr),
    .i_sample   (tri_out),
    .o_boundary (w_boundary)
  );

  // Program memory: writable only while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STEPS; i++) begin
        r_prog[i] <= '0;
      end
    end else if (wr_en && (r_state == IDLE)) begin
      r_prog[wr_addr] <= '{shift: wr_shift, rep: wr_rep};
    end
  end

`ifdef WAVE_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_fault;

  // Fires on the cycle the counter would wrap without a boundary.
  assign w_timeout = (r_state == RUN) && (&r_wd) && !w_boundary;
  assign fault     = r_fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd    <= '0;
      r_fault <= 1'b0;
    end else begin
      if ((r_state == RUN) && !w_boundary) begin
        r_wd <= r_wd + TIMEOUT_W'(1);
      end else begin
        r_wd <= '0;
      end
      if (w_timeout) begin
        r_fault <= 1'b1;
      end else if (w_start_ok) begin
        r_fault <= 1'b0;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = |TIMEOUT_W;
  assign w_timeout    = 1'b0;
  assign fault        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_step     <= '0;
      r_load_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_load_cnt <= w_load_cnt_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_load_cnt_nxt = r_load_cnt;
    w_rep_cnt_nxt  = r_rep_cnt;
    w_done_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (r_prog[0].rep == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt    = LOAD;
            w_step_nxt     = '0;
            w_load_cnt_nxt = '0;
          end
        end
      end
      LOAD: begin
        w_rep_cnt_nxt = '0;
        if (r_load_cnt == LOAD_CNT_W'(LOAD_CYCLES - 1)) begin
          w_state_nxt = RUN;
        end else begin
          w_load_cnt_nxt = r_load_cnt + LOAD_CNT_W'(1);
        end
      end
      RUN: begin
        if (w_timeout) begin
          w_state_nxt = IDLE;
          w_step_nxt  = '0;
        end else if (w_boundary) begin
          if (r_rep_cnt == (r_prog[r_step].rep - REP_W'(1))) begin
            w_rep_cnt_nxt  = '0;
            w_load_cnt_nxt = '0;
            if (!w_prog_end) begin
              w_state_nxt = LOAD;
              w_step_nxt  = w_step_inc;
            end else if (loop_en) begin
              w_state_nxt = LOAD;
              w_step_nxt  = '0;
            end else begin
              w_state_nxt = IDLE;
              w_step_nxt  = '0;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_step_nxt  = '0;
      end
    endcase
    if (stop) begin
      w_state_nxt = IDLE;
      w_step_nxt  = '0;
      w_done_nxt  = 1'b0;
    end
  end

  // Outputs are registered from the next-state values so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tri_reset <= 1'b1;
      r_tri_shift <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_tri_reset <= (w_state_nxt != RUN);
      r_tri_shift <= (w_state_nxt == IDLE) ? '0 : r_prog[w_step_nxt].shift;
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= w_done_nxt;
      r_wr_err    <= wr_en && (r_state != IDLE);
    end
  end

  assign tri_reset = r_tri_reset;
  assign tri_shift = r_tri_shift;
  assign step      = r_step;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_wave_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wave_sequencer                                               |
// | Purpose  : Self-checking bench for wave_sequencer with a behavioural       |
// |            triangle generator and a step/period reference model.          |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wave_sequencer;

  localparam int STEPS    = 8;
  localparam int TO_W     = 6;
  localparam int TO_LIMIT = 1 << TO_W;
`ifdef WAVE_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start, stop, loop_en, wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_shift;
  logic [3:0]  wr_rep;
  logic        wr_err;
  logic [15:0] tri_out;
  logic        tri_reset;
  logic [3:0]  tri_shift;
  logic [2:0]  step;
  logic        busy, done, fault;

  wave_sequencer #(
    .STEPS     (STEPS),
    .SHIFT_W   (4),
    .REP_W     (4),
    .OUT_W     (16),
    .TIMEOUT_W (TO_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_shift  (wr_shift),
    .wr_rep    (wr_rep),
    .wr_err    (wr_err),
    .tri_out   (tri_out),
    .tri_reset (tri_reset),
    .tri_shift (tri_shift),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  // Triangle generator stand-in: ramps 0 -> h*100 -> 0 over 2h cycles,
  // h = rate + 2. g_hold parks the output at a constant.
  int g_phase;
  bit g_hold;

  function automatic logic [15:0] tri_val(input int ph, input logic [3:0] sh);
    int h;
    int v;
    h = int'(sh) + 2;
    v = (ph <= h) ? ph : (2 * h - ph);
    return 16'(v * 100);
  endfunction

  always @(posedge clk) begin
    if (tri_reset) g_phase <= 0;
    else g_phase <= (g_phase + 1) % (2 * (int'(tri_shift) + 2));
  end

  assign tri_out = g_hold ? 16'd77 : tri_val(g_phase, tri_shift);

  // Reference model: mode 0 idle, 1 generator held in reset, 2 running.
  int   m_mode, m_step, m_load_left, m_left, m_prev, m_quiet;
  bit   m_fall, m_fault;
  int   m_shift [STEPS];
  int   m_rep   [STEPS];
  bit   e_done, e_werr, e_busy, e_trst;
  int   e_shift;
  bit   chk_en;

  function automatic void model_reset();
    m_mode = 0; m_step = 0; m_load_left = 0; m_left = 0;
    m_prev = 0; m_quiet = 0; m_fall = 0; m_fault = 0;
    for (int i = 0; i < STEPS; i++) begin
      m_shift[i] = 0;
      m_rep[i]   = 0;
    end
    e_done = 0; e_werr = 0; e_busy = 0; e_trst = 1; e_shift = 0;
  endfunction

  function automatic void begin_step(input int s);
    m_step = s; m_mode = 1; m_load_left = 2;
  endfunction

  always @(posedge clk) begin : model
    bit was_idle, bnd;
    int nxt;
    if (reset_n) begin
      was_idle = (m_mode == 0);
      e_done   = 0;
      e_werr   = wr_en && !was_idle;
      if (m_mode == 0) begin
        if (start && !stop) begin
          m_fault = 0;
          if (m_rep[0] == 0) e_done = 1;
          else begin_step(0);
        end
      end else if (m_mode == 1) begin
        m_load_left--;
        if (m_load_left == 0) begin
          m_mode = 2; m_left = m_rep[m_step];
          m_prev = 0; m_fall = 0; m_quiet = 0;
        end
      end else begin
        bnd = m_fall && (int'(tri_out) > m_prev);
        if (int'(tri_out) < m_prev) m_fall = 1;
        if (bnd) m_fall = 0;
        m_prev  = int'(tri_out);
        m_quiet = bnd ? 0 : m_quiet + 1;
        if (TO_EN && m_quiet == TO_LIMIT) begin
          m_fault = 1; m_mode = 0; m_step = 0;
        end else if (bnd) begin
          m_left--;
          if (m_left == 0) begin
            nxt = m_step + 1;
            if (nxt == STEPS || m_rep[nxt] == 0) begin
              if (loop_en) begin_step(0);
              else begin
                m_mode = 0; m_step = 0; e_done = 1;
              end
            end else begin
              begin_step(nxt);
            end
          end
        end
      end
      if (stop) begin
        m_mode = 0; m_step = 0; e_done = 0;
      end
      e_busy  = (m_mode != 0);
      e_trst  = (m_mode != 2);
      e_shift = m_shift[m_step];
      if (wr_en && was_idle) begin
        m_shift[wr_addr] = int'(wr_shift);
        m_rep[wr_addr]   = int'(wr_rep);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("busy",      int'(busy),      int'(e_busy));
      check_eq("tri_reset", int'(tri_reset), int'(e_trst));
      check_eq("step",      int'(step),      m_step);
      check_eq("done",      int'(done),      int'(e_done));
      check_eq("wr_err",    int'(wr_err),    int'(e_werr));
      check_eq("fault",     int'(fault),     int'(m_fault));
      if (e_busy) check_eq("tri_shift", int'(tri_shift), e_shift);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int s, input int r);
    wr_en = 1'b1; wr_addr = 3'(a); wr_shift = 4'(s); wr_rep = 4'(r);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic reset_pulse();
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("rst_tri_reset", int'(tri_reset), 1);
    check_eq("rst_tri_shift", int'(tri_shift), 0);
    check_eq("rst_step",      int'(step),      0);
    check_eq("rst_busy",      int'(busy),      0);
    check_eq("rst_done",      int'(done),      0);
    check_eq("rst_wr_err",    int'(wr_err),    0);
    check_eq("rst_fault",     int'(fault),     0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
  endtask

  task automatic load_demo();
    wr(0, 2, 3);
    wr(1, 5, 1);
    wr(2, 9, 0);
  endtask

  initial begin
    int len;
    reset_n = 1'b0; chk_en = 1'b0; g_hold = 1'b0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_shift = '0; wr_rep = '0;
    model_reset();
    cyc(3);
    reset_pulse();

    // Demo program, single pass.
    load_demo();
    pulse_start();
    cyc(90);

    // Same program looping, then aborted mid-step.
    loop_en = 1'b1;
    pulse_start();
    cyc(110);
    pulse_stop();
    cyc(3);
    loop_en = 1'b0;

    // Empty program.
    wr(0, 1, 0);
    pulse_start();
    cyc(4);

    // Write while running, then start+stop together while idle.
    load_demo();
    pulse_start();
    cyc(8);
    wr(1, 7, 7);
    cyc(4);
    pulse_stop();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    cyc(3);

    // Flat generator output: watchdog (when built) or stuck in RUN.
    g_hold = 1'b1;
    pulse_start();
    cyc(75);
    check_eq("wd_fault", int'(fault), int'(TO_EN));
    check_eq("wd_busy",  int'(busy),  int'(!TO_EN));
    pulse_stop();
    g_hold = 1'b0;
    cyc(2);

    // Reset in the middle of a run clears the program too.
    pulse_start();
    cyc(12);
    reset_pulse();
    pulse_start();
    cyc(3);

    // Randomised programs with control and write-port noise.
    for (int ep = 0; ep < 40; ep++) begin
      pulse_stop();
      len = $urandom_range(1, STEPS);
      for (int i = 0; i < STEPS; i++) begin
        if (i < len) wr(i, $urandom_range(0, 3), $urandom_range(1, 3));
        else if (i == len) wr(i, $urandom_range(0, 3), 0);
      end
      loop_en = 1'($urandom_range(0, 1));
      pulse_start();
      for (int c = 0; c < 150; c++) begin
        start    = ($urandom_range(0, 39) == 0);
        stop     = ($urandom_range(0, 149) == 0);
        wr_en    = ($urandom_range(0, 24) == 0);
        wr_addr  = 3'($urandom);
        wr_shift = 4'($urandom_range(0, 3));
        wr_rep   = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 59) == 0) loop_en = ~loop_en;
        @(negedge clk);
      end
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    end

    cyc(2);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wave_sequencer.md
# wave_sequencer

Program-driven controller for the badge's triangle-wave generator. Holds a short program of (rate, repeat) steps, drives the generator's synchronous reset and `shift_by` input, counts completed wave periods by watching the generator's 16-bit output, and advances through the program. The block sits between the host/register logic and one triangle generator instance, which makes LED fade patterns such as "slow breathe ×3, fast ×5, loop" autonomous.

## Interface
- `STEPS`, 8: program depth; power of two, ≥2
- `SHIFT_W`, 4: width of the generator rate field
- `REP_W`, 4: width of the per-step period count
- `OUT_W`, 16: width of the generator output
- `TIMEOUT_W`, 24: watchdog counter width (only used with the macro)

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level-sampled; begins the program from step 0 when idle
- `stop`  in  1  aborts immediately; returns to idle
- `loop_en`  in  1  when 1, the end of the program wraps to step 0
- `wr_en`  in  1  program write strobe
- `wr_addr`  in  $clog2(STEPS)  program slot
- `wr_shift`  in  SHIFT_W  rate for slot
- `wr_rep`  in  REP_W  periods for slot; 0 = end-of-program marker
- `wr_err`  out  1  one-cycle pulse: write dropped because the block is busy
- `tri_out`  in  OUT_W  generator output
- `tri_reset`  out  1  active-high synchronous reset to the generator
- `tri_shift`  out  SHIFT_W  to generator `shift_by`
- `step`  out  $clog2(STEPS)  current step index
- `busy`  out  1  high in LOAD/RUN
- `done`  out  1  one-cycle pulse when the program ends without a loop
- `fault`  out  1  sticky watchdog flag; tied 0 without the macro

## Operation
- Reset values: `tri_reset`=1, `tri_shift`=0, `step`=0, `busy`=0, `done`=0, `wr_err`=0, `fault`=0, program memory all zero, state IDLE.
- States: IDLE, LOAD, RUN.
- IDLE: `tri_reset`=1, which parks the generator output at 0. The block accepts writes. On `start`:
  - If `prog[0].rep`==0: pulse `done`, stay in IDLE.
  - Otherwise: go to LOAD with `step`=0.
- LOAD: lasts exactly 2 cycles with `tri_reset`=1 and `tri_shift`=`prog[step].shift`. It clears the period counter and the direction tracker, then goes to RUN.
- RUN: `tri_reset`=0.
  - Direction tracker: the block registers the previous `tri_out`.
    - A cycle with `tri_out` < prev sets `falling`.
    - A cycle with `tri_out` > prev while `falling`=1 is a period boundary; it clears `falling`.
    - Equal samples change nothing.
  - On each boundary the period counter increments. When the count reaches `prog[step].rep`, the block advances.
- Advance:
  - If `step`==STEPS-1 or `prog[step+1].rep`==0, the program has ended:
    - `loop_en`=1: `step`←0, go to LOAD.
    - `loop_en`=0: go to IDLE and pulse `done`.
  - Otherwise `step`←`step`+1, go to LOAD.
- `stop` in any state: IDLE next cycle, `step`←0, no `done`. Simultaneous `start`+`stop`: `stop` wins.
- `start` while busy is ignored.
- `wr_en` while busy: the memory is unchanged and `wr_err` pulses.
- `loop_en` is sampled only at the end-of-program decision.

## Timing
- `start` high in cycle N → cycles N+1 and N+2 are LOAD (`busy`=1, `tri_reset`=1) → `tri_reset`=0 from N+3.
- All outputs are registered; none combinational from inputs.
- A boundary seen at cycle M that completes a step puts the block in LOAD at M+1.
- `done` is high for exactly the cycle in which `busy` first reads 0.
- A write in IDLE cycle N is visible to a `start` in cycle N+1.

## Configuration
- `WAVE_SEQ_TIMEOUT_EN` defined: a TIMEOUT_W-bit counter runs in RUN and clears on each boundary and in LOAD.
  - On overflow, the block sets `fault` (sticky until `reset_n` or the next accepted `start`) and goes to IDLE without `done`.
- Undefined: no counter is built and `fault` is constant 0.

## Structure
- Shared package `wave_seq_pkg`:
  - state enum `{IDLE, LOAD, RUN}`
  - program-entry struct `{shift, rep}`
  - `LOAD_CYCLES`=2
- One sub-module `wave_period_detect`: prev-sample register, `falling` flag, `boundary` pulse output, synchronous clear input.
- The program memory is a flop array with a write port in the top level.

## Test plan
- Reset mid-RUN (`reset_n` low for 1 cycle) → all outputs at reset values in the same cycle; memory cleared.
- Program {(2,3),(5,1),(x,0)}, `loop_en`=0, behavioural triangle model, `start` pulse → `tri_shift`=2 for 3 periods, then 5 for 1 period; `done` one cycle; `step` sequence 0,1,0.
- Same program with `loop_en`=1 → returns to step 0 after step 1 with a 2-cycle LOAD; no `done`; `stop` mid-step → IDLE next cycle, `tri_reset`=1.
- Step 0 rep=0, `start` → `done` at N+1, `busy` never high.
- Write during RUN → `wr_err` pulse, readback unchanged; simultaneous `start`+`stop` in IDLE → stays IDLE.
- Macro on, TIMEOUT_W=6, `tri_out` held constant → `fault`=1 and IDLE 64 cycles after entering RUN; macro off → stays in RUN.
